// File: rtl/vital_scan_alarm_if.sv
// rtl/vital_scan_alarm_if.sv - sensor mux link, limits, sample and alarm signals of vital_scan_alarm
interface vital_scan_alarm_if #(
    parameter int DW = 8
);
    logic          enable;
    logic [DW-1:0] mux_out;
    logic [DW-1:0] lo0;
    logic [DW-1:0] hi0;
    logic [DW-1:0] lo1;
    logic [DW-1:0] hi1;
    logic [1:0]    ack;
    logic          select;
    logic [DW-1:0] sample;
    logic          sample_ch;
    logic          sample_valid;
    logic [1:0]    alarm;
    logic          busy;

    modport master (
        output enable, mux_out, lo0, hi0, lo1, hi1, ack,
        input  select, sample, sample_ch, sample_valid, alarm, busy
    );

    modport slave (
        input  enable, mux_out, lo0, hi0, lo1, hi1, ack,
        output select, sample, sample_ch, sample_valid, alarm, busy
    );
endinterface

// File: rtl/vital_scan_alarm.sv
// rtl/vital_scan_alarm.sv - two-channel vital sign scanner with debounced sticky alarms
// Optional macro ALARM_AUTOCLEAR_EN: alarms self-clear after CLR_CNT consecutive in-range samples.
module vital_scan_alarm #(
    parameter int DW       = 8,
    parameter int SETTLE   = 2,
    parameter int DEBOUNCE = 3,
    parameter int CLR_CNT  = 4
) (
    input  logic               clk,
    input  logic               reset,
    vital_scan_alarm_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_CHECK  = 2'd3;

    // One counter width covers both the debounce and auto-clear thresholds.
    localparam int CNT_MAX = (DEBOUNCE > CLR_CNT) ? DEBOUNCE : CLR_CNT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [1:0]          state_q, state_d;
    logic [3:0]          settle_q, settle_d;
    logic                select_q, select_d;
    logic [DW-1:0]       sample_q, sample_d;
    logic                sample_ch_q, sample_ch_d;
    logic [1:0]          alarm_q, alarm_d;
    logic [1:0][CW-1:0]  dbc_q, dbc_d;
`ifdef ALARM_AUTOCLEAR_EN
    logic [1:0][CW-1:0]  clr_q, clr_d;
`endif

    logic [DW-1:0] lo_sel, hi_sel;
    logic          out_of_range;

    assign lo_sel       = sample_ch_q ? bus.lo1 : bus.lo0;
    assign hi_sel       = sample_ch_q ? bus.hi1 : bus.hi0;
    assign out_of_range = (sample_q < lo_sel) || (sample_q > hi_sel);

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        select_d    = select_q;
        sample_d    = sample_q;
        sample_ch_d = sample_ch_q;
        dbc_d       = dbc_q;
        alarm_d     = alarm_q & ~bus.ack;
`ifdef ALARM_AUTOCLEAR_EN
        for (int c = 0; c < 2; c++) begin
            clr_d[c] = alarm_q[c] ? clr_q[c] : '0;
        end
`endif
        if (!bus.enable) begin
            state_d  = ST_IDLE;
            select_d = 1'b0;
            dbc_d    = '0;
`ifdef ALARM_AUTOCLEAR_EN
            clr_d    = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SETTLE;
                    settle_d = 4'(SETTLE - 1);
                    select_d = 1'b0;
                end
                ST_SETTLE: begin
                    if (settle_q == 4'd0) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        settle_d = settle_q - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    sample_d    = bus.mux_out;
                    sample_ch_d = select_q;
                    state_d     = ST_CHECK;
                end
                default: begin
                    // Set is applied after the ack clear so a coincident set wins.
                    if (out_of_range) begin
                        if (dbc_q[sample_ch_q] != CW'(DEBOUNCE)) begin
                            dbc_d[sample_ch_q] = dbc_q[sample_ch_q] + 1'b1;
                        end
                        if (dbc_q[sample_ch_q] == CW'(DEBOUNCE - 1)) begin
                            alarm_d[sample_ch_q] = 1'b1;
                        end
                    end else begin
                        dbc_d[sample_ch_q] = '0;
                    end
`ifdef ALARM_AUTOCLEAR_EN
                    if (alarm_q[sample_ch_q]) begin
                        if (out_of_range) begin
                            clr_d[sample_ch_q] = '0;
                        end else if (clr_q[sample_ch_q] == CW'(CLR_CNT - 1)) begin
                            clr_d[sample_ch_q]   = '0;
                            alarm_d[sample_ch_q] = 1'b0;
                        end else begin
                            clr_d[sample_ch_q] = clr_q[sample_ch_q] + 1'b1;
                        end
                    end
`endif
                    select_d = ~select_q;
                    settle_d = 4'(SETTLE - 1);
                    state_d  = ST_SETTLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            select_q    <= 1'b0;
            sample_q    <= '0;
            sample_ch_q <= 1'b0;
            alarm_q     <= '0;
            dbc_q       <= '0;
`ifdef ALARM_AUTOCLEAR_EN
            clr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            select_q    <= select_d;
            sample_q    <= sample_d;
            sample_ch_q <= sample_ch_d;
            alarm_q     <= alarm_d;
            dbc_q       <= dbc_d;
`ifdef ALARM_AUTOCLEAR_EN
            clr_q       <= clr_d;
`endif
        end
    end

    // An enable drop during CHECK discards the sample, so the pulse is gated.
    assign bus.sample_valid = (state_q == ST_CHECK) && bus.enable;
    assign bus.select       = select_q;
    assign bus.sample       = sample_q;
    assign bus.sample_ch    = sample_ch_q;
    assign bus.alarm        = alarm_q;
    assign bus.busy         = (state_q != ST_IDLE);
endmodule

// File: doc/vital_scan_alarm.md
Name: vital_scan_alarm

Overview:
- Drives the select line of the two-input sensor mux bank. Channel 0 is heart rate; channel 1 is body temperature.
- Alternates between the two channels and waits for the mux output to settle before sampling it.
- Checks each sample against per-channel low/high limits and debounces out-of-range readings into sticky per-channel alarms for the nurse-call logic.
- Sits directly downstream of the mux, consuming its output, and also produces the mux select.

Parameters:
- DW, 8, width of the sensor value on the mux output and of all limits.
- SETTLE, 2, cycles held after a select change before sampling (1..15).
- DEBOUNCE, 3, consecutive out-of-range samples needed to raise an alarm (1..15).
- CLR_CNT, 4, consecutive in-range samples that auto-clear an alarm (only used with ALARM_AUTOCLEAR_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scanning runs while high.
- mux_out  in  DW  selected sensor value from the mux bank.
- lo0, hi0  in  DW each  channel 0 inclusive limits.
- lo1, hi1  in  DW each  channel 1 inclusive limits.
- ack  in  2  per-channel alarm acknowledge, one-cycle pulse.
- select  out  1  mux select; 0 selects channel 0.
- sample  out  DW  last captured value.
- sample_ch  out  1  channel of the last captured value.
- sample_valid  out  1  one-cycle pulse when sample updates.
- alarm  out  2  sticky per-channel alarm.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async): state=IDLE; select=0, sample=0, sample_ch=0, sample_valid=0, alarm=0, busy=0. Debounce and clear counters are 0.
- FSM states: IDLE, SETTLE, SAMPLE, CHECK.
- IDLE: with enable=1, go to SETTLE with select=0 on the next edge.
- SETTLE:
  - select is held steady.
  - The settle counter loads SETTLE-1 on entry and counts down.
  - At 0, go to SAMPLE. SETTLE lasts exactly SETTLE cycles.
- SAMPLE (1 cycle): at the exit edge, sample<=mux_out and sample_ch<=select. Go to CHECK.
- CHECK (1 cycle):
  - sample_valid=1 in this cycle only.
  - Out-of-range for channel c means sample<lo_c or sample>hi_c, unsigned compare. A value equal to a limit is in range.
  - Out-of-range: the channel's debounce counter increments, saturating at DEBOUNCE. In-range: it clears to 0.
  - The alarm bit is set at the exit edge of the CHECK that brings the counter to DEBOUNCE.
  - Exit edge: select toggles and the FSM goes to SETTLE.
- Timing:
  - Per-channel period is SETTLE+2 cycles; full scan is 2*(SETTLE+2) cycles.
  - The alarm is visible the cycle after the triggering CHECK.
- ack[c] clears alarm[c] at the next edge. If ack[c] and a set occur at the same edge, set wins and the alarm stays 1. ack on a bit that is already clear has no effect.
- The alarm stays set while the counter remains saturated. It is re-raised only after the counter falls below DEBOUNCE and returns to it.
- enable dropped in any state:
  - Return to IDLE at the next edge; the in-progress sample is discarded with no sample_valid.
  - Debounce counters clear to 0; alarm and sample hold; select returns to 0.
- lo_c > hi_c: every sample is out-of-range. This is legal; no special handling.
- Limits are sampled combinationally in CHECK. Changing limits mid-scan takes effect at the next CHECK.
- Async reset mid-operation aborts immediately to reset values.

Optional Feature:
- Macro: ALARM_AUTOCLEAR_EN.
- Defined:
  - A per-channel clear counter counts consecutive in-range samples while alarm[c]=1; an out-of-range sample resets it to 0.
  - At CLR_CNT, alarm[c] clears at that CHECK exit edge and the counter resets.
  - ack still clears the alarm immediately.
- Undefined: only ack clears alarms; no clear counters exist.

Test Plan:
- Reset while scanning: assert reset mid-SETTLE -> all outputs 0 in the same cycle; with enable=1 after release, select=0 for 2 cycles, then sample_valid pulses at cycle 4 counting IDLE exit as cycle 1.
- Scan order: enable=1; mux_out follows select (ch0=70, ch1=37); limits 50..120 and 35..39 -> sample_valid every 4 cycles; sample alternates 70/37 and sample_ch 0/1; alarm stays 00.
- Debounce: ch0 mux_out=130, hi0=120, DEBOUNCE=3 -> alarm[0] rises after the 3rd ch0 CHECK, not the 2nd. An in-range ch0 sample after 2 bad ones resets the count, so no alarm.
- Boundaries and ack:
  - ch1=35 with lo1=35 gives no alarm; ch1=34 gives an alarm after 3 samples.
  - ack[1] pulsed on the same edge as a setting CHECK leaves alarm[1]=1.
  - ack[1] alone clears it.
- Enable drop: deassert enable in SAMPLE -> IDLE next cycle, no sample_valid, select=0, alarm held, debounce restarts from 0.
- ALARM_AUTOCLEAR_EN, CLR_CNT=4: after alarm[0] is set, 4 consecutive in-range ch0 samples clear it. 3 good, 1 bad, then 3 good does not clear it.
